// File: rtl/inst_encoder.sv
// inst_encoder: two-stage valid/ready pipeline that packs RV32I instruction fields into a 32-bit word.
// Define INST_ENC_RANGE_CHECK_EN to enable immediate range checking, the error flag and the error counters.
module inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    input  logic        clear_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic        out_err_o,
    output logic        err_sticky_o,
    output logic [7:0]  err_count_o,
    output logic [15:0] enc_count_o
);

    typedef enum logic [2:0] {
        FMT_R      = 3'd0,
        FMT_I      = 3'd1,
        FMT_S      = 3'd2,
        FMT_B      = 3'd3,
        FMT_U      = 3'd4,
        FMT_J      = 3'd5,
        FMT_ISHIFT = 3'd6,
        FMT_CSRI   = 3'd7
    } fmt_e;

    // Handshake: a word moves across an interface on the rising edge where valid and ready are
    // both high; a producer holds valid and payload until that edge, ready may change at any time.
    logic        s1_valid;
    fmt_e        s1_fmt;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;
    logic [31:0] s1_word;

    logic        s2_valid;
    logic [31:0] s2_inst;

    logic        s2_free;
    logic        in_take;
    logic        out_fire;
    logic [15:0] enc_count;

    assign s2_free    = !s2_valid || out_ready_i;
    assign in_ready_o = !s1_valid || s2_free;
    assign in_take    = in_valid_i && in_ready_o;
    assign out_fire   = s2_valid && out_ready_i;

    // Stage 1: raw fields; it is refilled whenever it is empty or handing its word on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= FMT_R;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_imm    <= '0;
        end else begin
            if (in_ready_o) begin
                s1_valid <= in_valid_i;
            end
            if (in_take) begin
                s1_fmt    <= fmt_e'(fmt_i);
                s1_opcode <= opcode_i;
                s1_rd     <= rd_i;
                s1_rs1    <= rs1_i;
                s1_rs2    <= rs2_i;
                s1_funct3 <= funct3_i;
                s1_funct7 <= funct7_i;
                s1_imm    <= imm_i;
            end
        end
    end

    // Packing truncates the immediate to the bits each format carries; the error bit reports overflow.
    always_comb begin
        s1_word = '0;
        case (s1_fmt)
            FMT_R:           s1_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_I, FMT_CSRI: s1_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_ISHIFT:      s1_word = {s1_funct7, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S:           s1_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            FMT_B:           s1_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                        s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_U:           s1_word = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J:           s1_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                        s1_rd, s1_opcode};
            default:         s1_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_inst  <= '0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_inst <= s1_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
        end else if (clear_i) begin
            enc_count <= '0;
        end else if (out_fire) begin
            enc_count <= enc_count + 16'd1;
        end
    end

    assign out_valid_o = s2_valid;
    assign out_inst_o  = s2_inst;
    assign enc_count_o = enc_count;

`ifdef INST_ENC_RANGE_CHECK_EN
    logic       in_err;
    logic       s1_err;
    logic       s2_err;
    logic       err_sticky;
    logic [7:0] err_count;

    // "All equal" upper bits is the sign-extension test for a signed field of that width.
    always_comb begin
        in_err = 1'b0;
        case (fmt_e'(fmt_i))
            FMT_I, FMT_S: in_err = !((&imm_i[31:11]) || !(|imm_i[31:11]));
            FMT_B:        in_err = !((&imm_i[31:12]) || !(|imm_i[31:12])) || imm_i[0];
            FMT_J:        in_err = !((&imm_i[31:20]) || !(|imm_i[31:20])) || imm_i[0];
            FMT_U:        in_err = |imm_i[11:0];
            FMT_ISHIFT:   in_err = |imm_i[31:5];
            FMT_CSRI:     in_err = |imm_i[31:12];
            default:      in_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err <= 1'b0;
            s2_err <= 1'b0;
        end else begin
            if (in_take) begin
                s1_err <= in_err;
            end
            if (s2_free && s1_valid) begin
                s2_err <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clear_i) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (out_fire && s2_err) begin
            err_sticky <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign out_err_o    = s2_err;
    assign err_sticky_o = err_sticky;
    assign err_count_o  = err_count;
`else
    assign out_err_o    = 1'b0;
    assign err_sticky_o = 1'b0;
    assign err_count_o  = 8'h00;
`endif

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32I instruction encoder. It takes instruction fields (format, opcode, register indices, funct fields, and a 32-bit immediate) and packs them into a 32-bit instruction word; it performs the inverse of the ID-stage immediate generation. It sits in front of the BIOS/IMEM program loader and the self-test instruction generator. It is a 2-stage valid/ready pipeline with optional immediate range checking and status counters.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: encoder accepts a request this cycle.
- `fmt_i` in 3: format select.
  - 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 I-shift, 7 CSR-imm.
  - I covers JALR, LOAD and ARI-I; U covers LUI and AUIPC.
- `opcode_i` in 7: inst[6:0].
- `rd_i`, `rs1_i`, `rs2_i` in 5 each: register fields; for CSR-imm, `rs1_i` carries zimm.
- `funct3_i` in 3, `funct7_i` in 7: function fields.
- `imm_i` in 32: byte immediate, sign-extended. For CSR-imm it holds the CSR address.
- `clear_i` in 1: synchronous clear of status counters and sticky flag.
- `out_valid_o` out 1: encoded word valid.
- `out_ready_i` in 1: downstream accepts.
- `out_inst_o` out 32: encoded instruction.
- `out_err_o` out 1: immediate was out of range for its format.
- `err_sticky_o` out 1: set by any emitted word with error.
- `err_count_o` out 8: saturating count of emitted error words.
- `enc_count_o` out 16: wrapping count of emitted words.

## Operation
Packing (bit ranges are imm bits):
- R: {funct7, rs2, rs1, funct3, rd, opcode}.
- I: {imm[11:0], rs1, funct3, rd, opcode}.
- I-shift: {funct7, imm[4:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- U: {imm[31:12], rd, opcode}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- CSR-imm: {imm[11:0], rs1(zimm), funct3, rd, opcode}.

Fields not used by a format are ignored.

Range rules (range check compiled in):
- I, S: imm[31:11] all equal.
- B: imm[31:12] all equal and imm[0]=0.
- J: imm[31:20] all equal and imm[0]=0.
- U: imm[11:0]=0.
- I-shift: imm[31:5]=0.
- CSR-imm: imm[31:12]=0.
- R: never errors.

A violation does not block output. The word is emitted with the immediate truncated as packed and `out_err_o`=1.

Pipeline:
- S1 captures the fields and computes the error bit.
- S2 holds the packed word, the error bit and `out_valid_o`.
- Each stage advances when its successor is empty or draining.
- `in_ready_o` = !s1_valid | (!s2_valid | out_ready_i).
- Bubbles collapse.

Counters:
- On each output handshake (`out_valid_o & out_ready_i`), `enc_count_o` increments, wrapping 0xFFFF→0.
- If the handshake carries an error, `err_count_o` also increments (saturating at 0xFF) and `err_sticky_o` is set.
- `clear_i` zeroes both counters and the sticky flag. It has priority over a same-cycle increment.
- `clear_i` does not touch pipeline contents.

## Timing
- Reset values: `in_ready_o`=1; all other outputs are 0, including `out_valid_o`, `out_inst_o`, `out_err_o`, the counters and the sticky flag.
- Reset mid-operation flushes both stages immediately; in-flight requests are lost.
- Latency: handshake accepted in cycle N gives `out_valid_o`=1 in cycle N+2 with no backpressure.
- Throughput: 1 word/cycle.
- Holding output: while `out_valid_o` & !`out_ready_i`, the `out_inst_o` and `out_err_o` values are stable.
- Order is preserved. A stall holds at most 2 requests before `in_ready_o` drops.
- All outputs are registered, except `in_ready_o`, which is combinational from `out_ready_i` and stage state.
- Simultaneous output handshake and input accept are supported in every cycle.

## Configuration
- With `INST_ENC_RANGE_CHECK_EN` defined, the range rules apply and the error outputs and counters operate as above.
- Without the macro:
  - there is no range logic;
  - `out_err_o`, `err_sticky_o` and `err_count_o` are constant 0;
  - packing and truncation are unchanged;
  - `enc_count_o` still counts.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → `out_valid_o`=0 and counters 0 within the same cycle; `in_ready_o`=1 after release.
- **I-type:** fmt=1, opcode=0x13, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF → `out_inst_o`=0xFFF10093 two cycles after accept; `out_err_o`=0.
- **B- and J-type:** B with opcode=0x63, rs1=1, rs2=2, imm=0xFFFFFFFC → 0xFE208EE3. J with opcode=0x6F, rd=1, imm=0x800 → 0x001000EF.
- **Range error:** fmt=1, imm=0x800 → `out_inst_o`[31:20]=0x800, `out_err_o`=1, `err_count_o`=1, `err_sticky_o`=1. Without the macro: `out_err_o`=0, `err_count_o`=0.
- **Backpressure:** 4 back-to-back requests with `out_ready_i`=0 for 3 cycles → `in_ready_o`=0 after 2 held; all 4 words emerge in order with none duplicated; `enc_count_o`=4.
- **Counter edges:**
  - preload via 255 error words, then 1 more → `err_count_o` stays 0xFF;
  - `clear_i` coincident with a handshake → counters read 0 next cycle;
  - after 65536 words → `enc_count_o` wraps to 0.
